// File: rtl/feeder_pkg.sv
// Shared types and constants for the skew-buffer operand feeder.
// Optional build macro: FEEDER_PERF_EN (stall-cycle counter, see skew_feeder).
package feeder_pkg;

    localparam int LANES        = 4;
    localparam int DATA_W       = 8 * LANES;
    localparam int DRAIN_CYCLES = LANES - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/feeder_addr_gen.sv
// Read address generator: walks base, base+1, ... and tracks how many
// words remain so the FSM knows which issue is the last one.
module feeder_addr_gen #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] remaining;

    // Address rolls over naturally at 2^ADDR_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= base;
            remaining <= len;
        end else if (advance) begin
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - ADDR_W'(1);
        end
    end

    assign last = (remaining == ADDR_W'(1));

endmodule

// File: rtl/skew_feeder.sv
// Streams k_len words from a 1-cycle-latency buffer to the skew buffer, then
// flushes LANES-1 zero cycles and pulses done. Optional: FEEDER_PERF_EN.
module skew_feeder
    import feeder_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LANES  = feeder_pkg::LANES,
    parameter int DATA_W = 8 * LANES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] k_len,
    input  logic              stall,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [DATA_W-1:0] buf_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              done
`ifdef FEEDER_PERF_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    localparam int DRAIN_N    = LANES - 1;
    localparam int DRAIN_LAST = (DRAIN_N > 0) ? DRAIN_N - 1 : 0;
    localparam int CNT_W      = $clog2(LANES + 1);

    state_t            state_q, state_d;
    logic              load, advance, last, drain_inc;
    logic [CNT_W-1:0]  drain_cnt;
    logic [1:0]        vld_pipe;  // [0] read in flight, [1] word on out_data

    feeder_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (advance),
        .base    (base_addr),
        .len     (k_len),
        .addr    (buf_addr),
        .last    (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        advance   = 1'b0;
        buf_rd_en = 1'b0;
        drain_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = (k_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (!stall) begin
                    buf_rd_en = 1'b1;
                    advance   = 1'b1;
                    if (last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Flush count only begins once the final word has left out_data.
                if (vld_pipe == 2'b00) begin
                    if (drain_cnt == CNT_W'(DRAIN_LAST)) state_d = DONE;
                    else                                 drain_inc = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  drain_cnt <= '0;
        else if (state_q != DRAIN) drain_cnt <= '0;
        else if (drain_inc)       drain_cnt <= drain_cnt + CNT_W'(1);
    end

    // Zero whenever no word is valid so the skew stages see clean bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= 2'b00;
            out_data <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], buf_rd_en};
            out_data <= vld_pipe[0] ? buf_rd_data : '0;
        end
    end

    assign out_valid = vld_pipe[1];
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

`ifdef FEEDER_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (state_q == IDLE && start)
            stall_cycles <= '0;
        else if (state_q == FETCH && stall && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
    end
`endif

endmodule

// File: tb/tb_skew_feeder.sv
// Directed bench for skew_feeder with a behavioural 1-cycle-latency buffer.
module tb_skew_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] k_len;
    logic        stall;
    logic        buf_rd_en;
    logic [15:0] buf_addr;
    logic [31:0] buf_rd_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        busy;
    logic        done;
`ifdef FEEDER_PERF_EN
    logic [15:0] stall_cycles;
`endif

    int n_vec = 0;
    int n_err = 0;

    skew_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .k_len        (k_len),
        .stall        (stall),
        .buf_rd_en    (buf_rd_en),
        .buf_addr     (buf_addr),
        .buf_rd_data  (buf_rd_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .busy         (busy),
        .done         (done)
`ifdef FEEDER_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Both halves carry the address so every data bit is exercised.
    function automatic logic [31:0] word(input logic [15:0] a);
        return {~a, a};
    endfunction

    // Unread cycles return junk so un-gated data paths show up on out_data.
    always @(posedge clk)
        buf_rd_data <= buf_rd_en ? word(buf_addr) : $urandom();

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start at cycle T, then check every cycle T+1 .. T+done_off+1.
    // smask[c] drives stall in cycle T+c; ign_at pulses a bogus start.
    task automatic run(input logic [15:0] base, input logic [15:0] k,
                       input logic [63:0] smask, input int ign_at, input int done_off);
        logic        exp_ov [0:63];
        logic [31:0] exp_od [0:63];
        logic [15:0] ea;
        logic        exp_rd;
        int          issued;
        for (int i = 0; i < 64; i++) begin
            exp_ov[i] = 1'b0;
            exp_od[i] = 32'h0;
        end
        issued = 0;
        @(negedge clk);
        start = 1'b1; base_addr = base; k_len = k; stall = 1'b0;
        for (int c = 1; c <= done_off + 1; c++) begin
            @(negedge clk);
            if (c == ign_at) begin
                start = 1'b1; base_addr = 16'h9999; k_len = 16'd7;
            end else begin
                start = 1'b0;
            end
            stall = smask[c];
            #1;
            exp_rd = (32'(issued) < 32'(k)) && !smask[c];
            chk("rd_en", 32'(buf_rd_en), 32'(exp_rd));
            if (exp_rd) begin
                ea = base + 16'(issued);
                chk("addr", 32'(buf_addr), 32'(ea));
                exp_ov[c + 2] = 1'b1;
                exp_od[c + 2] = word(ea);
                issued++;
            end
            chk("out_valid", 32'(out_valid), 32'(exp_ov[c]));
            chk("out_data", out_data, exp_od[c]);
            chk("busy", 32'(busy), 32'(c <= done_off));
            chk("done", 32'(done), 32'(c == done_off));
        end
        stall = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; base_addr = '0; k_len = '0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_rd_en", 32'(buf_rd_en), 32'h0);
        chk("rst_addr", 32'(buf_addr), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst = 1'b0;

        run(16'h0010, 16'd4, 64'h0, 0, 10);            // basic stream
        run(16'h0020, 16'd3, 64'h4, 0, 10);            // one stall bubble at T+2
        run(16'hFFFE, 16'd4, 64'h0, 0, 10);            // address wrap
        run(16'h0030, 16'd0, 64'h0, 0, 1);             // zero length
        run(16'h0040, 16'd3, 64'h0, 2, 9);             // start ignored in FETCH
        run(16'h0050, 16'd4, 64'h3E, 0, 15);           // stall T+1..T+5
`ifdef FEEDER_PERF_EN
        chk("stall_cycles_after", 32'(stall_cycles), 32'd5);
`endif
        run(16'h0060, 16'd2, 64'h0, 0, 8);
`ifdef FEEDER_PERF_EN
        chk("stall_cycles_clear", 32'(stall_cycles), 32'd0);
`endif

        // Reset in the middle of a k_len=8 run.
        @(negedge clk);
        start = 1'b1; base_addr = 16'h0100; k_len = 16'd8;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("mid_rd_en", 32'(buf_rd_en), 32'h1);
        chk("mid_addr", 32'(buf_addr), 32'h0102);
        rst = 1'b1; #1;
        chk("mrst_rd_en", 32'(buf_rd_en), 32'h0);
        chk("mrst_addr", 32'(buf_addr), 32'h0);
        chk("mrst_out_data", out_data, 32'h0);
        chk("mrst_out_valid", 32'(out_valid), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
        chk("mrst_done", 32'(done), 32'h0);
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_rd_en", 32'(buf_rd_en), 32'h0);
        run(16'h0200, 16'd2, 64'h0, 0, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
